gf_mult_serial: RTL and testbench
=================================

GF_MULT_SERIAL -- requirements
Module: gf_mult_serial

Interface
REQ-001 Parameter LANES, default 4: number of independent byte lanes; legal 1..16.
REQ-002 Parameter STEP, default 2: multiplier bits consumed per cycle; legal 1, 2, 4, 8.
REQ-003 Parameter POLY, default 8'h1D: low byte of field polynomial (x^8 implied); default gives 0x11D.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  operand bundle valid.
REQ-007 in_ready  output  1  block can accept a bundle.
REQ-008 a_in  input  LANES*8  multiplicand; lane i = bits [8i+7:8i].
REQ-009 b_in  input  LANES*8  multiplier; lane i = bits [8i+7:8i].
REQ-010 out_valid  output  1  product bundle valid.
REQ-011 out_ready  input  1  consumer accepts product.
REQ-012 p_out  output  LANES*8  per-lane GF(2^8) product a*b mod (x^8+POLY).

Function
REQ-013 The block SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-014 in_ready SHALL be 1 in IDLE, and 1 in DONE when out_ready=1; 0 otherwise.
REQ-015 Accept = in_valid & in_ready; on accept, the block SHALL latch a_in and b_in, clear every lane accumulator, clear the step counter and enter BUSY.
REQ-016 In BUSY, each cycle SHALL apply STEP Horner steps per lane, MSB of b first: acc = xtime(acc) XOR (bit ? a : 0), where xtime(x) = {x[6:0],0} XOR (x[7] ? POLY : 0).
REQ-017 The step counter SHALL count 0..8/STEP-1; on the terminal count the block SHALL enter DONE, with final products in p_out.
REQ-018 Latency: out_valid SHALL rise exactly 8/STEP clock edges after the accepting edge.
REQ-019 In DONE, out_valid SHALL be 1 and p_out SHALL remain stable until out_valid & out_ready.
REQ-020 On handshake in DONE without a new accept, the block SHALL return to IDLE and out_valid SHALL drop on the next edge.
REQ-021 On handshake in DONE with a simultaneous accept, the block SHALL go directly to BUSY with the new operands: no bubble.
REQ-022 in_valid and operand changes in BUSY SHALL be ignored; operands are sampled only on accept.
REQ-023 All lanes SHALL share one FSM and counter and complete together.
REQ-024 p_out SHALL equal the accumulators at all times; it is valid only while out_valid=1.

Reset
REQ-025 On rst_n=0, at any time including mid-BUSY, the FSM SHALL go to IDLE, the counter, accumulators and latched operands SHALL clear to 0, out_valid SHALL be 0 and p_out SHALL be 0.
REQ-026 An in-flight operation interrupted by reset SHALL be discarded with no output produced.
REQ-027 in_ready SHALL be 1 from the first cycle after rst_n deasserts.

Structure
REQ-028 The shared package anubis_gf_pkg SHALL hold the default POLY constant, the FSM state typedef and the xtime function.
REQ-029 One sub-module, gf_mul_step (combinational: acc, a and STEP b-bits in, new acc out, POLY parameter), SHALL be instantiated once per lane.
REQ-030 Elaboration SHALL fail for an illegal STEP or LANES value.

Verification
REQ-031 LANES=1, STEP=1: a=0x40, b=0x04 -> p_out=0x1D, out_valid on the 8th edge after accept.
REQ-032 STEP=2, LANES=4: a=0x80 and b=0x04 in all lanes -> all lanes 0x3A after 4 cycles; also a=0xFF with b=0x01 -> 0xFF, and a=0x00 with b=0xA5 -> 0x00.
REQ-033 Exhaustive: b=0x04 for all 256 values of a, for each STEP in {1,2,4,8} -> matches the 4*x table (0x00->0x00, 0x3F->0xFC, 0x40->0x1D, 0xFF->0xDB); products are commutative.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles in DONE -> p_out stable, in_ready=0; then raise out_ready with in_valid=1 -> new operands accepted in the same cycle, no idle cycle.
REQ-035 Assert rst_n=0 in the 2nd BUSY cycle -> out_valid=0, p_out=0, in_ready=1 after release, and no stale product ever appears.

Source files
------------

// File: rtl/anubis_gf_pkg.sv
// Shared GF(2^8) definitions: default field polynomial, FSM state type and
// the multiply-by-x helper used by every lane.
package anubis_gf_pkg;

  // Low byte of x^8 + x^4 + x^3 + x^2 + 1 (0x11D); the x^8 term is implied.
  localparam logic [7:0] DEFAULT_POLY = 8'h1D;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Multiply by x, then reduce modulo x^8 + poly.
  function automatic logic [7:0] xtime(input logic [7:0] x, input logic [7:0] poly);
    return {x[6:0], 1'b0} ^ (x[7] ? poly : 8'h00);
  endfunction

endpackage

// File: rtl/gf_mul_step.sv
// One lane's combinational Horner slice: folds STEP multiplier bits (MSB
// first) into the running GF(2^8) accumulator.
module gf_mul_step
  import anubis_gf_pkg::*;
#(
  parameter int         STEP = 2,
  parameter logic [7:0] POLY = DEFAULT_POLY
) (
  input  logic [7:0]      acc,
  input  logic [7:0]      a,
  input  logic [STEP-1:0] bits,
  output logic [7:0]      acc_nxt
);

  logic [7:0] t;

  // NOTE: t gets a value before the loop so no path leaves it unassigned;
  // otherwise synthesis would infer a latch.
  always_comb begin
    t = acc;
    for (int k = STEP - 1; k >= 0; k--) begin
      t = xtime(t, POLY) ^ (bits[k] ? a : 8'h00);
    end
    acc_nxt = t;
  end

endmodule

// File: rtl/gf_mult_serial.sv
// Multi-lane serial GF(2^8) multiplier: one shared IDLE/BUSY/DONE FSM, STEP
// multiplier bits per lane per cycle, valid/ready on both sides.
module gf_mult_serial
  import anubis_gf_pkg::*;
#(
  parameter int         LANES = 4,
  parameter int         STEP  = 2,
  parameter logic [7:0] POLY  = DEFAULT_POLY
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*8-1:0] a_in,
  input  logic [LANES*8-1:0] b_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*8-1:0] p_out
);

  localparam int N_STEPS = 8 / STEP;
  localparam int CNT_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;

  generate
    if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8)) begin : g_bad_step
      $error("gf_mult_serial: STEP must be 1, 2, 4 or 8");
    end
    if (LANES < 1 || LANES > 16) begin : g_bad_lanes
      $error("gf_mult_serial: LANES must be in 1..16");
    end
  endgenerate

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [LANES*8-1:0] a_q;
  logic [LANES*8-1:0] b_q;
  logic [LANES*8-1:0] acc;
  logic [LANES*8-1:0] acc_nxt;
  logic               accept;
  logic               last_step;

  // Ready also in DONE while the consumer drains, so back-to-back bundles
  // flow without an idle cycle.
  assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign last_step = (cnt == CNT_W'(N_STEPS - 1));
  assign p_out     = acc;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [STEP-1:0] bits;

    // The counter walks the latched multiplier from its MSB downwards.
    assign bits = b_q[8*i + 7 - STEP*int'(cnt) -: STEP];

    gf_mul_step #(
      .STEP (STEP),
      .POLY (POLY)
    ) u_step (
      .acc     (acc[8*i +: 8]),
      .a       (a_q[8*i +: 8]),
      .bits    (bits),
      .acc_nxt (acc_nxt[8*i +: 8])
    );
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operands and accumulators are reset too, so p_out reads zero
      // and no stale product survives a reset.
      state     <= ST_IDLE;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      state     <= ST_BUSY;
      cnt       <= '0;
      a_q       <= a_in;
      b_q       <= b_in;
      acc       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_BUSY: begin
          acc <= acc_nxt;
          if (last_step) begin
            state     <= ST_DONE;
            cnt       <= '0;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf_mult_serial.sv
// Directed bench: five gf_mult_serial instances (STEP 1/2/4/8 with 4 lanes,
// plus a 1-lane STEP 1) driven with shared operands and checked in parallel.
module tb_gf_mult_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [4:0]  ov;
  logic [4:0]  ir;
  logic [31:0] po [4];
  logic [7:0]  po_l1;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam int LAT [5] = '{8, 4, 2, 1, 8};

  always #5 clk = ~clk;

  gf_mult_serial #(.LANES(4), .STEP(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .a_in(a_in), .b_in(b_in), .out_valid(ov[0]), .out_ready(out_ready), .p_out(po[0]));
  gf_mult_serial #(.LANES(4), .STEP(2)) dut_s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .a_in(a_in), .b_in(b_in), .out_valid(ov[1]), .out_ready(out_ready), .p_out(po[1]));
  gf_mult_serial #(.LANES(4), .STEP(4)) dut_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
    .a_in(a_in), .b_in(b_in), .out_valid(ov[2]), .out_ready(out_ready), .p_out(po[2]));
  gf_mult_serial #(.LANES(4), .STEP(8)) dut_s8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]),
    .a_in(a_in), .b_in(b_in), .out_valid(ov[3]), .out_ready(out_ready), .p_out(po[3]));
  gf_mult_serial #(.LANES(1), .STEP(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[4]),
    .a_in(a_in[7:0]), .b_in(b_in[7:0]), .out_valid(ov[4]), .out_ready(out_ready), .p_out(po_l1));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference: LSB-first shift-and-add multiply modulo 0x11D.
  function automatic logic [7:0] gf_ref(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) r ^= x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1D) : {x[6:0], 1'b0};
    end
    return r;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (ir !== 5'h1F && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (ir !== 5'h1F) check("wait_ready timeout", 32'(ir), 32'h1F);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e,
                        input string tag);
    int          lat [5];
    logic [31:0] val [5];
    bit          got [5];
    wait_ready();
    a_in = a; b_in = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a_in = ~a; b_in = ~b;
    for (int j = 0; j < 5; j++) begin
      got[j] = 1'b0; lat[j] = -1; val[j] = 'x;
    end
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      for (int j = 0; j < 5; j++) begin
        if (ov[j] && !got[j]) begin
          got[j] = 1'b1;
          lat[j] = c;
          val[j] = (j == 4) ? {24'h0, po_l1} : po[j];
        end
      end
    end
    for (int j = 0; j < 5; j++) begin
      check($sformatf("%s dut%0d latency", tag, j), 32'(lat[j]), 32'(LAT[j]));
      check($sformatf("%s dut%0d product", tag, j), val[j], (j == 4) ? {24'h0, e[7:0]} : e);
    end
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{32'h80808080, 32'h04040404, 32'h3A3A3A3A};
    vecs[1] = '{32'hFFFFFFFF, 32'h01010101, 32'hFFFFFFFF};
    vecs[2] = '{32'h00000000, 32'hA5A5A5A5, 32'h00000000};
    vecs[3] = '{32'h3F40038E, 32'h04040302, 32'hFC1D0501};
    vecs[4] = '{32'hFF00403F, 32'h04040404, 32'hDB001DFC};
    vecs[5] = '{32'h04040302, 32'h3F40038E, 32'hFC1D0501};
    vecs[6] = '{32'h01028040, 32'hA5800204, 32'hA51D1D1D};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 32'(ov), 32'h0);
    check("reset p_out s2", po[1], 32'h0);
    check("reset p_out l1", 32'(po_l1), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready after reset", 32'(ir), 32'h1F);

    for (int i = 0; i < 7; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].e, $sformatf("vec%0d", i));

    // Every a in 0..255 across the four lanes, times 4, then the swapped order.
    for (int i = 0; i < 64; i++) begin
      logic [31:0] a, e;
      for (int l = 0; l < 4; l++) begin
        a[8*l +: 8] = 8'(i + 64 * l);
        e[8*l +: 8] = gf_ref(8'(i + 64 * l), 8'h04);
      end
      run_op(a, 32'h04040404, e, $sformatf("x4 a%0d", i));
      if (i % 4 == 0) run_op(32'h04040404, a, e, $sformatf("x4 swap%0d", i));
    end

    // Backpressure: hold the product for 5 cycles, then drain and accept together.
    begin
      int n = 0;
      int lat = -1;
      wait_ready();
      out_ready = 1'b0;
      a_in = 32'h80808080; b_in = 32'h04040404; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      while (!ov[1] && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      check("bp done seen", 32'(ov[1]), 32'h1);
      for (int k = 0; k < 5; k++) begin
        @(posedge clk); #1;
        check($sformatf("bp hold%0d p_out", k), po[1], 32'h3A3A3A3A);
        check($sformatf("bp hold%0d in_ready", k), 32'(ir[1]), 32'h0);
        check($sformatf("bp hold%0d out_valid", k), 32'(ov[1]), 32'h1);
      end
      out_ready = 1'b1; in_valid = 1'b1;
      a_in = 32'hFFFFFFFF; b_in = 32'h01010101;
      #1;
      check("bp in_ready on drain", 32'(ir[1]), 32'h1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp no bubble out_valid", 32'(ov[1]), 32'h0);
      for (int c = 1; c <= 8 && lat < 0; c++) begin
        @(posedge clk); #1;
        if (ov[1]) lat = c;
      end
      check("bp second latency", 32'(lat), 32'd4);
      check("bp second product", po[1], 32'hFFFFFFFF);
      repeat (12) @(posedge clk);
      #1;
    end

    // Reset in the second BUSY cycle: the operation must vanish.
    begin
      bit stale = 1'b0;
      wait_ready();
      a_in = 32'h80808080; b_in = 32'h04040404; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("midrst out_valid", 32'(ov), 32'h0);
      check("midrst p_out s2", po[1], 32'h0);
      check("midrst p_out s1", po[0], 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("midrst in_ready", 32'(ir), 32'h1F);
      for (int c = 0; c < 12; c++) begin
        if (ov != 5'h0) stale = 1'b1;
        @(posedge clk); #1;
      end
      check("midrst no stale product", 32'(stale), 32'h0);
      check("midrst p_out after", po[1], 32'h0);
    end

    run_op(vecs[3].a, vecs[3].b, vecs[3].e, "post reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
